// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MEM-stage load/store responder: word RAM plus LED/switch/cycle MMIO window.
// Optional cycle counter at MMIO offset 0x008 is built only when MEM_RESPONDER_CYCLE_CNT_EN is defined.
module mem_responder #(
    parameter int          RAM_DEPTH   = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FC00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        mem_stall,
    output logic        err,
    output logic [15:0] led,
    input  logic [15:0] sw
);
    localparam int AW = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_store;
    logic        r_conflict;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_led;
    logic [15:0] r_sw_s1;
    logic [15:0] r_sw_s2;
    logic [31:0] r_ram [RAM_DEPTH];

    logic          w_req;
    logic          w_start;
    logic          w_enter_done;
    logic [31:0]   w_a;
    logic [31:0]   w_d;
    logic          w_st;
    logic          w_conf;
    logic          w_misal;
    logic          w_mmio;
    logic          w_in_ram;
    logic          w_err;
    logic [AW-1:0] w_ram_idx;
    logic          w_ram_we;
    logic          w_led_we;
    logic [31:0]   w_rd;
    logic [31:0]   w_cycle;

`ifdef MEM_RESPONDER_CYCLE_CNT_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    assign w_req     = MemRead | MemWrite;
    assign w_start   = (r_state == S_IDLE) && w_req;
    assign mem_stall = w_req && (r_state != S_DONE);

    // With zero wait states the access resolves on the request edge, so use the live inputs.
    assign w_a    = w_start ? addr : r_addr;
    assign w_d    = w_start ? wdata : r_wdata;
    assign w_st   = w_start ? MemWrite : r_store;
    assign w_conf = w_start ? (MemRead & MemWrite) : r_conflict;

    assign w_enter_done = (w_start && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_WAIT) && (r_wait_cnt <= 4'd1));

    assign w_misal   = (w_a[1:0] != 2'b00);
    assign w_mmio    = (w_a[31:10] == MMIO_BASE[31:10]);
    assign w_in_ram  = !w_mmio && ((w_a >> (AW + 2)) == 32'd0);
    assign w_err     = w_misal || w_conf || (!w_mmio && !w_in_ram);
    assign w_ram_idx = w_a[AW+1:2];
    assign w_ram_we  = rst && w_enter_done && w_st && w_in_ram && !w_misal;
    assign w_led_we  = w_enter_done && w_st && w_mmio && !w_misal && (w_a[9:0] == 10'h000);

    always_comb begin
        w_rd = '0;
        if (!w_misal) begin
            if (w_mmio) begin
                case (w_a[9:0])
                    10'h000: w_rd = {16'b0, r_led};
                    10'h004: w_rd = {16'b0, r_sw_s2};
                    10'h008: w_rd = w_cycle;
                    default: w_rd = '0;
                endcase
            end else if (w_in_ram) begin
                w_rd = r_ram[w_ram_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= w_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_store    <= 1'b0;
            r_conflict <= 1'b0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_led      <= '0;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            if (w_enter_done) begin
                r_done <= 1'b1;
                r_err  <= w_err;
                if (!w_st) begin
                    r_rdata <= w_rd;
                end
                if (w_led_we) begin
                    r_led <= w_d[15:0];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                        r_store    <= MemWrite;
                        r_conflict <= MemRead & MemWrite;
                        r_wait_cnt <= 4'(WAIT_CYCLES);
                        r_state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt <= 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata = r_rdata;
    assign done  = r_done;
    assign err   = r_err;
    assign led   = r_led;
endmodule
